// File: rtl/pipeline_exec_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_exec_ctrl_pkg
// Shared definitions for the pipeline execution controller:
//   cmd_e    - debug host command encodings carried on i_cmd
//   state_e  - controller FSM states
//   isActive - states in which the pipeline is enabled
//   isReady  - states in which a host command can be accepted
// ---------------------------------------------------------------------------
package pipeline_exec_ctrl_pkg;

  typedef enum logic [1:0] {
    CMD_NOP  = 2'b00,
    CMD_RUN  = 2'b01,
    CMD_STEP = 2'b10,
    CMD_STOP = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } state_e;

  // The pipeline advances in every state that is executing or flushing a HALT.
  function automatic logic isActive(input state_e s);
    return (s == ST_RUN) || (s == ST_STEP) || (s == ST_DRAIN);
  endfunction

  // STEP and DRAIN are short, self-terminating sequences, so the host is held
  // off while they complete.
  function automatic logic isReady(input state_e s);
    return (s == ST_IDLE) || (s == ST_RUN) || (s == ST_HALTED);
  endfunction

endpackage

// File: rtl/pipeline_exec_ctrl_sat_counter.sv
// ---------------------------------------------------------------------------
// pipeline_exec_ctrl_sat_counter
// Saturating up-counter; sticks at all-ones instead of wrapping.
// Ports:
//   i_clk   in  1  clock, posedge
//   i_rst   in  1  synchronous active-high reset, clears the count
//   i_inc   in  1  increment request for this edge
//   o_count out W  current count
// ---------------------------------------------------------------------------
module pipeline_exec_ctrl_sat_counter #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  localparam logic [W-1:0] COUNT_MAX = '1;

  logic [W-1:0] count_q;

  // Count up on request, but hold once the maximum value has been reached so
  // long runs read back as "at least this many" rather than a small number.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_q <= '0;
    end else if (i_inc && (count_q != COUNT_MAX)) begin
      count_q <= count_q + W'(1);
    end
  end

  assign o_count = count_q;

endmodule

// File: rtl/pipeline_exec_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_exec_ctrl
// Execution controller producing the pipeline/PC enable. The debug host issues
// RUN / STEP / STOP commands; a HALT seen in IF lets the pipeline drain until
// the HALT retires, after which the pipeline is frozen until reset.
// Ports:
//   i_clk          in   1         clock, posedge
//   i_rst          in   1         synchronous active-high reset
//   i_cmd_valid    in   1         host command valid
//   i_cmd          in   2         00 NOP, 01 RUN, 10 STEP, 11 STOP
//   o_cmd_ready    out  1         command accepted when valid & ready
//   i_halt_fetched in   1         IF stage holds a HALT opcode
//   i_pc           in   NBITS     current PC
//   o_enable       out  1         pipeline / PC enable
//   o_busy         out  1         RUN, STEP or DRAIN
//   o_done         out  1         one-cycle pulse after run/step/drain ends
//   o_halted       out  1         sticky, HALT fully retired
//   o_halt_pc      out  NBITS     PC of the fetched HALT
//   o_cycle_count  out  CNT_BITS  saturating count of enabled cycles
// HALT_DRAIN must be at least 1.
// ---------------------------------------------------------------------------
module pipeline_exec_ctrl
  import pipeline_exec_ctrl_pkg::*;
#(
  parameter int NBITS      = 32,
  parameter int CNT_BITS   = 32,
  parameter int HALT_DRAIN = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_cmd_valid,
  input  logic [1:0]          i_cmd,
  output logic                o_cmd_ready,
  input  logic                i_halt_fetched,
  input  logic [NBITS-1:0]    i_pc,
  output logic                o_enable,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_halted,
  output logic [NBITS-1:0]    o_halt_pc,
  output logic [CNT_BITS-1:0] o_cycle_count
);

  localparam int DRAIN_W = $clog2(HALT_DRAIN + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(HALT_DRAIN);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(1);

  state_e             state_q, state_d;
  logic [DRAIN_W-1:0] drainCnt_q, drainCnt_d;
  logic [NBITS-1:0]   haltPc_q, haltPc_d;
  logic               active_q;
  logic               ready_q;
  logic               done_q, done_d;
  logic               halted_q;

  cmd_e cmd;
  logic cmdFire;

  assign cmd     = cmd_e'(i_cmd);
  assign cmdFire = i_cmd_valid & ready_q;

  // Next-state logic. A HALT fetch takes priority over any host command in the
  // same cycle, since the HALT is already in flight and must be allowed to
  // retire. Commands that have no meaning in the current state are accepted
  // and simply dropped. done_d flags the edge that ends the last enabled
  // cycle of a STEP, a STOP-terminated RUN, or a drain.
  always_comb begin
    state_d    = state_q;
    drainCnt_d = drainCnt_q;
    haltPc_d   = haltPc_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmdFire && (cmd == CMD_RUN)) begin
          state_d = ST_RUN;
        end else if (cmdFire && (cmd == CMD_STEP)) begin
          state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        if (i_halt_fetched) begin
          haltPc_d   = i_pc;
          drainCnt_d = DRAIN_INIT;
          state_d    = ST_DRAIN;
        end else if (cmdFire && (cmd == CMD_STOP)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      ST_STEP: begin
        if (i_halt_fetched) begin
          haltPc_d   = i_pc;
          drainCnt_d = DRAIN_INIT;
          state_d    = ST_DRAIN;
        end else begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      ST_DRAIN: begin
        // The counter holds the number of drain cycles still to run,
        // including the current one.
        if (drainCnt_q == DRAIN_LAST) begin
          state_d = ST_HALTED;
          done_d  = 1'b1;
        end else begin
          drainCnt_d = drainCnt_q - DRAIN_LAST;
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register plus registered Moore outputs. Outputs are computed from
  // the next state so they line up with the state they describe.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      drainCnt_q <= '0;
      haltPc_q   <= '0;
      active_q   <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      drainCnt_q <= drainCnt_d;
      haltPc_q   <= haltPc_d;
      active_q   <= isActive(state_d);
      ready_q    <= isReady(state_d);
      done_q     <= done_d;
      halted_q   <= (state_d == ST_HALTED);
    end
  end

  pipeline_exec_ctrl_sat_counter #(
    .W(CNT_BITS)
  ) uCycleCounter (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_inc  (active_q),
    .o_count(o_cycle_count)
  );

  assign o_enable    = active_q;
  assign o_busy      = active_q;
  assign o_cmd_ready = ready_q;
  assign o_done      = done_q;
  assign o_halted    = halted_q;
  assign o_halt_pc   = haltPc_q;

endmodule
